// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-set-2 constants and the scan-code to ASCII lookup.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // Each entry packs {unshifted, shifted} characters; unmapped codes give 0.
  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic shift);
    logic [15:0] pair;
    pair = '0;
    case (code)
      8'h1C: pair = "aA";  8'h32: pair = "bB";  8'h21: pair = "cC";  8'h23: pair = "dD";
      8'h24: pair = "eE";  8'h2B: pair = "fF";  8'h34: pair = "gG";  8'h33: pair = "hH";
      8'h43: pair = "iI";  8'h3B: pair = "jJ";  8'h42: pair = "kK";  8'h4B: pair = "lL";
      8'h3A: pair = "mM";  8'h31: pair = "nN";  8'h44: pair = "oO";  8'h4D: pair = "pP";
      8'h15: pair = "qQ";  8'h2D: pair = "rR";  8'h1B: pair = "sS";  8'h2C: pair = "tT";
      8'h3C: pair = "uU";  8'h2A: pair = "vV";  8'h1D: pair = "wW";  8'h22: pair = "xX";
      8'h35: pair = "yY";  8'h1A: pair = "zZ";
      8'h45: pair = "0)";  8'h16: pair = "1!";  8'h1E: pair = "2@";  8'h26: pair = "3#";
      8'h25: pair = "4$";  8'h2E: pair = "5%";  8'h36: pair = "6^";  8'h3D: pair = "7&";
      8'h3E: pair = "8*";  8'h46: pair = "9(";
      8'h4E: pair = "-_";  8'h55: pair = "=+";  8'h54: pair = "[{";  8'h5B: pair = "]}";
      8'h5D: pair = "\\|"; 8'h4C: pair = ";:";  8'h52: pair = "'\""; 8'h41: pair = ",<";
      8'h49: pair = ".>";  8'h4A: pair = "/?";  8'h0E: pair = "`~";
      8'h29: pair = {8'h20, 8'h20};
      8'h5A: pair = {8'h0D, 8'h0D};
      8'h66: pair = {8'h08, 8'h08};
      default: pair = '0;
    endcase
    return shift ? pair[7:0] : pair[15:8];
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchronizes and filters the pins, assembles 11-bit frames,
// checks start/parity/stop and drops partial frames after an idle timeout.
module ps2_frame_rx #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       byte_valid,
  output logic [7:0] data_byte
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          strobe;
  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic [TW-1:0] idle_cnt;
  logic          frame_ok;

  // Strobe fires on the same edge the filtered clock commits to low.
  assign strobe   = clk_filt && !clk_s2 && (flt_cnt == FW'(FILTER_LEN - 1));
  // sr holds {parity, d7..d0, start}; the stop bit is the live sample.
  assign frame_ok = !sr[0] && dat_s2 && (^sr[9:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_s1 <= ps2_clk_async;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data_async;
      dat_s2 <= dat_s1;
      if (clk_s2 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    byte_valid <= 1'b0;
    if (reset) begin
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      sr        <= '0;
      data_byte <= '0;
    end else if (strobe) begin
      idle_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= '0;
        if (frame_ok) begin
          byte_valid <= 1'b1;
          data_byte  <= sr[8:1];
        end
      end else begin
        sr      <= {dat_s2, sr[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt != 4'd0) begin
      if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard decoder: tracks F0/E0 prefixes and shift state, and publishes
// make/break pulses with the scan code and its ASCII translation.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic       key_pressed,
  output logic       key_released
);

  logic       byte_valid;
  logic [7:0] data_byte;
  logic       shift, break_pending, ext_pending;

  ps2_frame_rx #(
    .CLK_HZ    (CLK_HZ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk_async (ps2_clk_async),
    .ps2_data_async(ps2_data_async),
    .byte_valid    (byte_valid),
    .data_byte     (data_byte)
  );

  always_ff @(posedge clk) begin
    key_pressed  <= 1'b0;
    key_released <= 1'b0;
    if (reset) begin
      scan_code     <= '0;
      ascii_code    <= '0;
      shift         <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
    end else if (byte_valid) begin
      if (data_byte == PS2_BREAK) begin
        break_pending <= 1'b1;
      end else if (data_byte == PS2_EXT) begin
        ext_pending <= 1'b1;
      end else begin
        if (data_byte == PS2_LSHIFT || data_byte == PS2_RSHIFT)
          shift <= ~break_pending;
        scan_code <= data_byte;
        if (break_pending) begin
          key_released <= 1'b1;
        end else begin
          key_pressed <= 1'b1;
          ascii_code  <= ext_pending ? 8'h00 : ps2_to_ascii(data_byte, shift);
        end
        break_pending <= 1'b0;
        ext_pending   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed scenarios plus random key traffic checked
// against a table-driven keyboard model.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code, ascii_code;
  logic       key_pressed, key_released;

  int total = 0, passed = 0, failed = 0;
  int press_cyc = 0, rel_cyc = 0, both_cyc = 0;

  logic [7:0] lo_tab [256];
  logic [7:0] hi_tab [256];
  logic [7:0] keys [$];
  logic [7:0] m_scan = '0, m_ascii = '0;
  bit         m_shift = 0, m_brk = 0, m_ext = 0;
  int         m_press = 0, m_rel = 0;

  ps2_scan_decoder #(
    .CLK_HZ    (1_000_000),
    .FILTER_LEN(8),
    .TIMEOUT_US(200)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk_async (ps2_clk),
    .ps2_data_async(ps2_data),
    .scan_code     (scan_code),
    .ascii_code    (ascii_code),
    .key_pressed   (key_pressed),
    .key_released  (key_released)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_pressed) press_cyc <= press_cyc + 1;
    if (key_released) rel_cyc <= rel_cyc + 1;
    if (key_pressed && key_released) both_cyc <= both_cyc + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cycles(10);
      ps2_clk = 1'b0;
      cycles(20);
      ps2_clk = 1'b1;
      cycles(10);
    end
    ps2_data = 1'b1;
  endtask

  // Keyboard model: what a host sees for a sequence of received bytes.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      m_scan = b;
      if (m_brk) m_rel++;
      else begin
        m_press++;
        m_ascii = m_ext ? 8'h00 : (m_shift ? hi_tab[b] : lo_tab[b]);
      end
      if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".scan"}, scan_code, m_scan);
    check({tag, ".ascii"}, ascii_code, m_ascii);
    check({tag, ".press"}, press_cyc, m_press);
    check({tag, ".rel"}, rel_cyc, m_rel);
  endtask

  task automatic key_byte(input logic [7:0] b, input string tag);
    send_bits(mk_frame(b, 0, 0), 11);
    cycles(5);
    model_byte(b);
    check_model(tag);
  endtask

  initial begin
    logic [7:0] letter_sc [26];
    logic [7:0] digit_sc [10];
    string lows, ups, digs, sdigs;
    logic [7:0] k;
    int r;

    letter_sc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                  8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                  8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digit_sc  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    lows  = "abcdefghijklmnopqrstuvwxyz";
    ups   = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    digs  = "0123456789";
    sdigs = ")!@#$%^&*(";
    for (int i = 0; i < 256; i++) begin
      lo_tab[i] = '0;
      hi_tab[i] = '0;
    end
    for (int i = 0; i < 26; i++) begin
      lo_tab[letter_sc[i]] = lows[i];
      hi_tab[letter_sc[i]] = ups[i];
      keys.push_back(letter_sc[i]);
    end
    for (int i = 0; i < 10; i++) begin
      lo_tab[digit_sc[i]] = digs[i];
      hi_tab[digit_sc[i]] = sdigs[i];
      keys.push_back(digit_sc[i]);
    end
    lo_tab[8'h29] = 8'h20; hi_tab[8'h29] = 8'h20; keys.push_back(8'h29);
    lo_tab[8'h5A] = 8'h0D; hi_tab[8'h5A] = 8'h0D; keys.push_back(8'h5A);
    lo_tab[8'h66] = 8'h08; hi_tab[8'h66] = 8'h08; keys.push_back(8'h66);

    cycles(5);
    check("rst.scan", scan_code, 8'h00);
    check("rst.ascii", ascii_code, 8'h00);
    check("rst.press", key_pressed, 1'b0);
    check("rst.rel", key_released, 1'b0);
    reset = 1'b0;
    cycles(5);

    key_byte(8'h1C, "make_a");
    check("make_a.const", ascii_code, 8'h61);

    key_byte(8'hF0, "brk_pre");
    key_byte(8'h1C, "brk_a");

    key_byte(8'h12, "shift_on");
    key_byte(8'h1C, "shift_A");
    check("shift_A.const", ascii_code, 8'h41);
    key_byte(8'hF0, "shift_brk_pre");
    key_byte(8'h12, "shift_off");
    key_byte(8'h1C, "unshift_a");
    check("unshift_a.const", ascii_code, 8'h61);

    key_byte(8'h32, "make_b");
    send_bits(mk_frame(8'h1C, 1, 0), 11);
    cycles(5);
    check_model("bad_parity");
    send_bits(mk_frame(8'h1C, 0, 1), 11);
    cycles(5);
    check_model("bad_stop");

    send_bits(mk_frame(8'h55, 0, 0), 5);
    cycles(600);
    key_byte(8'h29, "after_timeout");
    check("after_timeout.const", ascii_code, 8'h20);

    key_byte(8'hE0, "ext_pre");
    key_byte(8'h75, "ext_75");
    check("ext_75.const", ascii_code, 8'h00);

    send_bits(mk_frame(8'h16, 0, 0), 5);
    reset = 1'b1;
    cycles(3);
    check("midrst.scan", scan_code, 8'h00);
    check("midrst.ascii", ascii_code, 8'h00);
    check("midrst.pulses", {30'd0, key_pressed, key_released}, 32'd0);
    reset = 1'b0;
    m_scan = '0; m_ascii = '0; m_shift = 0; m_brk = 0; m_ext = 0;
    cycles(5);
    key_byte(8'h45, "post_rst_0");
    check("post_rst_0.const", ascii_code, 8'h30);

    for (int n = 0; n < 30; n++) begin
      k = keys[$urandom_range(0, keys.size() - 1)];
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        key_byte(k, "rnd_make");
      end else if (r == 5) begin
        key_byte(8'hF0, "rnd_brk_pre");
        key_byte(k, "rnd_brk");
      end else if (r == 6) begin
        key_byte(($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59, "rnd_shift_on");
      end else if (r == 7) begin
        key_byte(8'hF0, "rnd_shift_brk_pre");
        key_byte(($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59, "rnd_shift_off");
      end else if (r == 8) begin
        key_byte(8'hE0, "rnd_ext_pre");
        key_byte(k, "rnd_ext");
      end else begin
        send_bits(mk_frame(k, 1, 0), 11);
        cycles(5);
        check_model("rnd_bad_parity");
      end
    end

    check("never_both", both_cyc, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
